// File: rtl/alu_rs_issue_if.sv
// Dispatch/issue handshake bundle for the ALU reservation station, plus the
// FU input payload type shared by dispatch, the RS and the ALU/CMP unit.
// master = dispatch driver / FU consumer; slave = the reservation station.
package alu_rs_issue_pkg;
  typedef struct packed {
    logic [3:0]  fu_op;
    logic [5:0]  rd_tag;
    logic [31:0] imm;
    logic        use_imm;
  } fu_input_t;
endpackage

interface alu_rs_issue_if
  import alu_rs_issue_pkg::*;
#(
  parameter int unsigned PREG_W = 6
);
  logic              dispatch_valid;
  logic              dispatch_ready;
  fu_input_t         dispatch_op;
  logic [PREG_W-1:0] dispatch_rs1_tag;
  logic [PREG_W-1:0] dispatch_rs2_tag;
  logic              dispatch_rs1_rdy;
  logic              dispatch_rs2_rdy;
  logic              issue_valid;
  logic              issue_ready;
  fu_input_t         issue_op;
  logic [PREG_W-1:0] issue_rs1_tag;
  logic [PREG_W-1:0] issue_rs2_tag;

  modport master (
    output dispatch_valid, dispatch_op, dispatch_rs1_tag, dispatch_rs2_tag,
    output dispatch_rs1_rdy, dispatch_rs2_rdy, issue_ready,
    input  dispatch_ready, issue_valid, issue_op, issue_rs1_tag, issue_rs2_tag
  );

  modport slave (
    input  dispatch_valid, dispatch_op, dispatch_rs1_tag, dispatch_rs2_tag,
    input  dispatch_rs1_rdy, dispatch_rs2_rdy, issue_ready,
    output dispatch_ready, issue_valid, issue_op, issue_rs1_tag, issue_rs2_tag
  );
endinterface

// File: rtl/alu_rs_issue.sv
// ALU/CMP reservation station: holds renamed ops until both source tags are
// ready (at dispatch or via CDB snoop), then issues one op per cycle.
// Optional macro RS_AGE_PRIORITY_EN: oldest-first select using per-entry age
// counters; when undefined, select is lowest-index eligible.
module alu_rs_issue
  import alu_rs_issue_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned CDB_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  alu_rs_issue_if.slave               rs_if,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*PREG_W-1:0] cdb_tag,
  output logic [$clog2(DEPTH):0]      occupancy
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef logic [PREG_W-1:0] tag_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d;
  logic [DEPTH-1:0] rs2_rdy_q, rs2_rdy_d;
  fu_input_t        op_q      [DEPTH];
  fu_input_t        op_d      [DEPTH];
  tag_t             rs1_tag_q [DEPTH];
  tag_t             rs1_tag_d [DEPTH];
  tag_t             rs2_tag_q [DEPTH];
  tag_t             rs2_tag_d [DEPTH];
  logic [CNT_W-1:0] occ_q, occ_d;
`ifdef RS_AGE_PRIORITY_EN
  logic [IDX_W-1:0] age_q     [DEPTH];
  logic [IDX_W-1:0] age_d     [DEPTH];
  logic [IDX_W-1:0] sel_age;
`endif

  logic [DEPTH-1:0] eligible;
  logic             alloc_found;
  logic [IDX_W-1:0] alloc_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_fire;
  logic             iss_fire;

  function automatic logic cdb_hit(input tag_t tag);
    cdb_hit = 1'b0;
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p] && (cdb_tag[p*PREG_W +: PREG_W] == tag)) cdb_hit = 1'b1;
    end
  endfunction

  assign eligible = valid_q & rs1_rdy_q & rs2_rdy_q;

  // Allocation target: lowest-index free entry (never the one issuing now,
  // since that entry is still valid in registered state).
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  // Issue select over registered readiness only (no CDB-to-issue path).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_AGE_PRIORITY_EN
    sel_age   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (eligible[i] && (!sel_found || (age_q[i] > sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_q[i];
      end
    end
`else
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (eligible[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
`endif
  end

  // Handshake outputs; payload forced to zero whenever nothing issues.
  always_comb begin
    rs_if.dispatch_ready = (occ_q < CNT_W'(DEPTH));
    rs_if.issue_valid    = sel_found && !flush;
    rs_if.issue_op       = '0;
    rs_if.issue_rs1_tag  = '0;
    rs_if.issue_rs2_tag  = '0;
    if (rs_if.issue_valid) begin
      rs_if.issue_op      = op_q[sel_idx];
      rs_if.issue_rs1_tag = rs1_tag_q[sel_idx];
      rs_if.issue_rs2_tag = rs2_tag_q[sel_idx];
    end
  end

  assign disp_fire = rs_if.dispatch_valid && rs_if.dispatch_ready && !flush;
  assign iss_fire  = rs_if.issue_valid && rs_if.issue_ready;
  assign occupancy = occ_q;

  // Next state: wakeup, free on issue, allocate on dispatch, flush wipes valid.
  always_comb begin
    valid_d   = valid_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    op_d      = op_q;
    rs1_tag_d = rs1_tag_q;
    rs2_tag_d = rs2_tag_q;
`ifdef RS_AGE_PRIORITY_EN
    age_d     = age_q;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (!rs1_rdy_q[i] && cdb_hit(rs1_tag_q[i])) rs1_rdy_d[i] = 1'b1;
        if (!rs2_rdy_q[i] && cdb_hit(rs2_tag_q[i])) rs2_rdy_d[i] = 1'b1;
`ifdef RS_AGE_PRIORITY_EN
        if (disp_fire && (age_q[i] != '1)) age_d[i] = age_q[i] + IDX_W'(1);
`endif
      end
    end
    if (iss_fire) valid_d[sel_idx] = 1'b0;
    if (disp_fire) begin
      valid_d[alloc_idx]   = 1'b1;
      op_d[alloc_idx]      = rs_if.dispatch_op;
      rs1_tag_d[alloc_idx] = rs_if.dispatch_rs1_tag;
      rs2_tag_d[alloc_idx] = rs_if.dispatch_rs2_tag;
      rs1_rdy_d[alloc_idx] = rs_if.dispatch_rs1_rdy || (rs_if.dispatch_rs1_tag == '0)
                             || cdb_hit(rs_if.dispatch_rs1_tag);
      rs2_rdy_d[alloc_idx] = rs_if.dispatch_rs2_rdy || (rs_if.dispatch_rs2_tag == '0)
                             || cdb_hit(rs_if.dispatch_rs2_tag);
`ifdef RS_AGE_PRIORITY_EN
      age_d[alloc_idx]     = '0;
`endif
    end
    occ_d = occ_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  // Control state: valid bits and occupancy, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Entry payload and readiness; only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    rs1_rdy_q <= rs1_rdy_d;
    rs2_rdy_q <= rs2_rdy_d;
    op_q      <= op_d;
    rs1_tag_q <= rs1_tag_d;
    rs2_tag_q <= rs2_tag_d;
`ifdef RS_AGE_PRIORITY_EN
    age_q     <= age_d;
`endif
  end

  // Occupancy bounds and allocation consistency.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (occ_q <= CNT_W'(DEPTH));
      assert (!(disp_fire && !alloc_found));
      assert (!(iss_fire && (occ_q == '0)));
    end
  end
endmodule

// File: tb/tb_alu_rs_issue.sv
// Directed bench for alu_rs_issue (DEPTH=8, PREG_W=6, CDB_PORTS=2).
module tb_alu_rs_issue;
  import alu_rs_issue_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [3:0]  occupancy;
  int          checks;
  int          failures;

  alu_rs_issue_if #(.PREG_W(6)) rs_if ();

  alu_rs_issue #(.DEPTH(8), .PREG_W(6), .CDB_PORTS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .rs_if     (rs_if.slave),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fu_input_t mkop(input int unsigned k);
    fu_input_t o;
    o.fu_op   = 4'(k);
    o.rd_tag  = 6'(k + 32);
    o.imm     = 32'hA000_0000 + k;
    o.use_imm = k[0];
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic v, input fu_input_t op, input logic [5:0] t1,
                          input logic r1, input logic [5:0] t2, input logic r2);
    rs_if.dispatch_valid   = v;
    rs_if.dispatch_op      = op;
    rs_if.dispatch_rs1_tag = t1;
    rs_if.dispatch_rs1_rdy = r1;
    rs_if.dispatch_rs2_tag = t2;
    rs_if.dispatch_rs2_rdy = r2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks += 5;
    if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    if (rs_if.dispatch_ready !== 1'b1) begin failures++; $display("FAIL reset_dready got=%b exp=1", rs_if.dispatch_ready); end
    if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL reset_ivalid got=%b exp=0", rs_if.issue_valid); end
    if (rs_if.issue_op !== '0) begin failures++; $display("FAIL reset_iop got=%h exp=0", rs_if.issue_op); end
    if (rs_if.issue_rs1_tag !== 6'd0 || rs_if.issue_rs2_tag !== 6'd0) begin
      failures++; $display("FAIL reset_tags got=%0d/%0d exp=0/0", rs_if.issue_rs1_tag, rs_if.issue_rs2_tag);
    end
    rst = 1'b1;
  endtask

  task automatic test_fill();
    rs_if.issue_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rs_if.dispatch_ready !== 1'b1) begin failures++; $display("FAIL fill_dready_%0d got=%b exp=1", k, rs_if.dispatch_ready); end
      set_disp(1'b1, mkop(k), 6'(k + 1), 1'b1, 6'(k + 10), 1'b1);
      step();
      checks++;
      if (occupancy !== 4'(k + 1)) begin failures++; $display("FAIL fill_occ_%0d got=%0d exp=%0d", k, occupancy, k + 1); end
    end
    checks++;
    if (rs_if.dispatch_ready !== 1'b0) begin failures++; $display("FAIL full_dready got=%b exp=0", rs_if.dispatch_ready); end
    set_disp(1'b1, mkop(99), 6'd1, 1'b1, 6'd1, 1'b1);
    step();
    set_disp(1'b0, '0, 6'd0, 1'b0, 6'd0, 1'b0);
    checks++;
    if (occupancy !== 4'd8) begin failures++; $display("FAIL ninth_ignored got=%0d exp=8", occupancy); end
    rs_if.issue_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rs_if.issue_valid !== 1'b1 || rs_if.issue_op !== mkop(k) ||
          rs_if.issue_rs1_tag !== 6'(k + 1) || rs_if.issue_rs2_tag !== 6'(k + 10)) begin
        failures++;
        $display("FAIL drain_%0d got v=%b op=%h t=%0d/%0d exp v=1 op=%h t=%0d/%0d", k, rs_if.issue_valid,
                 rs_if.issue_op, rs_if.issue_rs1_tag, rs_if.issue_rs2_tag, mkop(k), k + 1, k + 10);
      end
      step();
    end
    rs_if.issue_ready = 1'b0;
    checks++;
    if (occupancy !== 4'd0 || rs_if.issue_valid !== 1'b0) begin
      failures++; $display("FAIL drain_empty got occ=%0d v=%b exp occ=0 v=0", occupancy, rs_if.issue_valid);
    end
  endtask

  task automatic test_wakeup();
    set_disp(1'b1, mkop(5), 6'd5, 1'b0, 6'd0, 1'b0);
    step();
    set_disp(1'b0, '0, 6'd0, 1'b0, 6'd0, 1'b0);
    step();
    checks++;
    if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL wake_wait got=%b exp=0", rs_if.issue_valid); end
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd5};
    #1;
    checks++;
    if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL wake_nocomb got=%b exp=0", rs_if.issue_valid); end
    step();
    cdb_valid = 2'b00;
    cdb_tag   = '0;
    #1;
    checks++;
    if (rs_if.issue_valid !== 1'b1 || rs_if.issue_rs1_tag !== 6'd5 || rs_if.issue_rs2_tag !== 6'd0 ||
        rs_if.issue_op !== mkop(5)) begin
      failures++; $display("FAIL wake_issue got v=%b t=%0d/%0d exp v=1 t=5/0", rs_if.issue_valid,
                           rs_if.issue_rs1_tag, rs_if.issue_rs2_tag);
    end
    rs_if.issue_ready = 1'b1;
    step();
    rs_if.issue_ready = 1'b0;
    checks++;
    if (occupancy !== 4'd0) begin failures++; $display("FAIL wake_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_race();
    // Tag 9 on the invalid port and tag 8 on the valid port must not wake it.
    set_disp(1'b1, mkop(9), 6'd9, 1'b0, 6'd3, 1'b1);
    cdb_valid = 2'b10;
    cdb_tag   = {6'd8, 6'd9};
    step();
    set_disp(1'b0, '0, 6'd0, 1'b0, 6'd0, 1'b0);
    cdb_valid = 2'b00;
    step();
    checks++;
    if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL race_nohit got=%b exp=0", rs_if.issue_valid); end
    cdb_valid = 2'b10;
    cdb_tag   = {6'd9, 6'd0};
    step();
    cdb_valid = 2'b00;
    checks++;
    if (rs_if.issue_valid !== 1'b1 || rs_if.issue_rs1_tag !== 6'd9) begin
      failures++; $display("FAIL race_port1_wake got v=%b t=%0d exp v=1 t=9", rs_if.issue_valid, rs_if.issue_rs1_tag);
    end
    rs_if.issue_ready = 1'b1;
    step();
    rs_if.issue_ready = 1'b0;
    // Dispatch and matching broadcast in the same cycle.
    set_disp(1'b1, mkop(11), 6'd0, 1'b0, 6'd9, 1'b0);
    cdb_valid = 2'b10;
    cdb_tag   = {6'd9, 6'd0};
    step();
    set_disp(1'b0, '0, 6'd0, 1'b0, 6'd0, 1'b0);
    cdb_valid = 2'b00;
    checks++;
    if (rs_if.issue_valid !== 1'b1 || rs_if.issue_op !== mkop(11) || rs_if.issue_rs2_tag !== 6'd9) begin
      failures++; $display("FAIL race_same_cycle got v=%b op=%h exp v=1 op=%h", rs_if.issue_valid, rs_if.issue_op, mkop(11));
    end
    rs_if.issue_ready = 1'b1;
    step();
    rs_if.issue_ready = 1'b0;
    checks++;
    if (occupancy !== 4'd0) begin failures++; $display("FAIL race_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_back_to_back();
    fu_input_t exp_op [7];
    for (int k = 0; k < 8; k++) begin
      set_disp(1'b1, mkop(20 + k), 6'(k + 1), 1'b1, 6'd0, 1'b1);
      step();
    end
    rs_if.issue_ready = 1'b1;
    set_disp(1'b1, mkop(40), 6'd2, 1'b1, 6'd0, 1'b1);
    #1;
    checks++;
    if (rs_if.dispatch_ready !== 1'b0 || rs_if.issue_op !== mkop(20)) begin
      failures++; $display("FAIL b2b_full got dready=%b op=%h exp dready=0 op=%h", rs_if.dispatch_ready, rs_if.issue_op, mkop(20));
    end
    step();
    checks++;
    if (occupancy !== 4'd7 || rs_if.dispatch_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_reject got occ=%0d dready=%b exp occ=7 dready=1", occupancy, rs_if.dispatch_ready);
    end
    step();
    set_disp(1'b0, '0, 6'd0, 1'b0, 6'd0, 1'b0);
    checks++;
    if (occupancy !== 4'd7) begin failures++; $display("FAIL b2b_net_zero got=%0d exp=7", occupancy); end
`ifdef RS_AGE_PRIORITY_EN
    for (int j = 0; j < 6; j++) exp_op[j] = mkop(22 + j);
    exp_op[6] = mkop(40);
`else
    exp_op[0] = mkop(40);
    for (int j = 1; j < 7; j++) exp_op[j] = mkop(21 + j);
`endif
    for (int j = 0; j < 7; j++) begin
      checks++;
      if (rs_if.issue_valid !== 1'b1 || rs_if.issue_op !== exp_op[j]) begin
        failures++; $display("FAIL b2b_order_%0d got v=%b op=%h exp v=1 op=%h", j, rs_if.issue_valid, rs_if.issue_op, exp_op[j]);
      end
      step();
    end
    rs_if.issue_ready = 1'b0;
    checks++;
    if (occupancy !== 4'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      set_disp(1'b1, mkop(50 + k), 6'd1, 1'b1, 6'd2, 1'b1);
      step();
    end
    flush = 1'b1;
    set_disp(1'b1, mkop(60), 6'd1, 1'b1, 6'd2, 1'b1);
    rs_if.issue_ready = 1'b1;
    #1;
    checks++;
    if (rs_if.issue_valid !== 1'b0 || occupancy !== 4'd5) begin
      failures++; $display("FAIL flush_cycle got v=%b occ=%0d exp v=0 occ=5", rs_if.issue_valid, occupancy);
    end
    step();
    flush = 1'b0;
    set_disp(1'b0, '0, 6'd0, 1'b0, 6'd0, 1'b0);
    checks++;
    if (occupancy !== 4'd0 || rs_if.issue_valid !== 1'b0) begin
      failures++; $display("FAIL flush_after got occ=%0d v=%b exp occ=0 v=0", occupancy, rs_if.issue_valid);
    end
    step();
    checks++;
    if (occupancy !== 4'd0 || rs_if.issue_valid !== 1'b0) begin
      failures++; $display("FAIL flush_stale got occ=%0d v=%b exp occ=0 v=0", occupancy, rs_if.issue_valid);
    end
    rs_if.issue_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      set_disp(1'b1, mkop(70 + k), 6'd1, 1'b1, 6'd1, 1'b1);
      step();
    end
    set_disp(1'b0, '0, 6'd0, 1'b0, 6'd0, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (occupancy !== 4'd0 || rs_if.issue_valid !== 1'b0 || rs_if.dispatch_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid got occ=%0d v=%b dr=%b exp occ=0 v=0 dr=1", occupancy,
                           rs_if.issue_valid, rs_if.dispatch_ready);
    end
  endtask

  task automatic test_age_priority();
    // Entries 0..2 ready, entry 3 (A) waits on tag 12.
    for (int k = 0; k < 3; k++) begin
      set_disp(1'b1, mkop(80 + k), 6'd1, 1'b1, 6'd1, 1'b1);
      step();
    end
    set_disp(1'b1, mkop(90), 6'd12, 1'b0, 6'd0, 1'b1);
    step();
    set_disp(1'b0, '0, 6'd0, 1'b0, 6'd0, 1'b0);
    rs_if.issue_ready = 1'b1;
    step();
    step();
    step();
    rs_if.issue_ready = 1'b0;
    checks++;
    if (occupancy !== 4'd1 || rs_if.issue_valid !== 1'b0) begin
      failures++; $display("FAIL age_setup got occ=%0d v=%b exp occ=1 v=0", occupancy, rs_if.issue_valid);
    end
    set_disp(1'b1, mkop(91), 6'd3, 1'b1, 6'd4, 1'b1);
    step();
    set_disp(1'b0, '0, 6'd0, 1'b0, 6'd0, 1'b0);
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd12};
    step();
    cdb_valid = 2'b00;
    checks++;
`ifdef RS_AGE_PRIORITY_EN
    if (rs_if.issue_op !== mkop(90)) begin failures++; $display("FAIL age_first got=%h exp=%h", rs_if.issue_op, mkop(90)); end
`else
    if (rs_if.issue_op !== mkop(91)) begin failures++; $display("FAIL age_first got=%h exp=%h", rs_if.issue_op, mkop(91)); end
`endif
    rs_if.issue_ready = 1'b1;
    step();
    checks++;
`ifdef RS_AGE_PRIORITY_EN
    if (rs_if.issue_op !== mkop(91)) begin failures++; $display("FAIL age_second got=%h exp=%h", rs_if.issue_op, mkop(91)); end
`else
    if (rs_if.issue_op !== mkop(90)) begin failures++; $display("FAIL age_second got=%h exp=%h", rs_if.issue_op, mkop(90)); end
`endif
    step();
    rs_if.issue_ready = 1'b0;
    checks++;
    if (occupancy !== 4'd0) begin failures++; $display("FAIL age_drain got=%0d exp=0", occupancy); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    cdb_valid = 2'b00;
    cdb_tag   = '0;
    rs_if.issue_ready = 1'b0;
    set_disp(1'b0, '0, 6'd0, 1'b0, 6'd0, 1'b0);
    test_reset();
    test_fill();
    test_wakeup();
    test_race();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_age_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_rs_issue.md
Name: alu_rs_issue

Overview:
Reservation station that feeds the ALU/CMP functional unit. It accepts renamed ALU/branch/jump ops from dispatch and tracks source-operand readiness by physical tag, snooping CDB broadcasts. Each cycle it issues one ready op as an fu_input_t, plus the rs1/rs2 tags that drive the physical-register read producing fu_reg_data. It is the producer end of the FU input interface.

Parameters:
DEPTH, 8, number of entries (power of 2, >=2)
PREG_W, 6, physical register tag width; tag 0 is x0 and always ready
CDB_PORTS, 2, number of CDB wakeup broadcast ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset (0 = reset)
flush  in  1  pipeline flush (mispredict), active-high
dispatch_valid  in  1  dispatch offers an op
dispatch_ready  out  1  at least one free entry
dispatch_op  in  $bits(fu_input_t)  op payload, stored verbatim
dispatch_rs1_tag  in  PREG_W  rs1 physical tag
dispatch_rs2_tag  in  PREG_W  rs2 physical tag
dispatch_rs1_rdy  in  1  rs1 already valid in PRF
dispatch_rs2_rdy  in  1  rs2 already valid in PRF
cdb_valid  in  CDB_PORTS  per-port broadcast valid
cdb_tag  in  CDB_PORTS*PREG_W  per-port produced tag; port i = bits [i*PREG_W +: PREG_W]
issue_valid  out  1  issue_op is valid this cycle
issue_ready  in  1  FU accepts
issue_op  out  $bits(fu_input_t)  op to FU
issue_rs1_tag  out  PREG_W  PRF read address rs1
issue_rs2_tag  out  PREG_W  PRF read address rs2
occupancy  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Per entry: valid, op, rs1_tag, rs2_tag, rs1_rdy, rs2_rdy (all registered).
- Reset (rst=0 at posedge): all valid=0, occupancy=0. Outputs then: dispatch_ready=1, issue_valid=0, issue_op/tags=0.
- Dispatch accept: dispatch_valid && dispatch_ready && !flush. Op is written into the lowest-index free entry.
- dispatch_ready derives only from registered state: occupancy<DEPTH. A same-cycle issue does not free a slot for that cycle's dispatch.
- Source ready at allocation: src_rdy = dispatch_srcN_rdy OR tag==0 OR (any cdb_valid[i] with cdb_tag[i]==tag). Same-cycle CDB match must not be lost.
- Wakeup: every valid entry compares each not-ready source against all CDB ports every cycle. A match sets rdy at the next edge.
- Eligible entry: valid && rs1_rdy && rs2_rdy, using registered bits. An entry woken at edge N can issue in the cycle after edge N; there is no combinational CDB-to-issue path.
- Select: default is the lowest-index eligible entry. issue_valid = any eligible && !flush. issue_op and tags are combinational from the selected entry. When issue_valid=0, issue_op/tags are 0.
- Issue handshake: issue_valid && issue_ready frees the selected entry at the edge. Without issue_ready the selection may change next cycle if a higher-priority entry becomes eligible.
- Simultaneous dispatch and issue: both happen. Occupancy is net-zero. Dispatch never targets the entry being freed that cycle.
- Full: occupancy==DEPTH gives dispatch_ready=0, and dispatch_valid is ignored.
- Flush: at the edge all valid=0 and occupancy=0. Dispatch and issue are both suppressed in the flush cycle (issue_valid=0). CDB in a flush cycle has no lasting effect.
- Occupancy: +1 on accepted dispatch, −1 on accepted issue. It never wraps; DEPTH and 0 are hard bounds (assert).
- Reset mid-operation: identical to reset; in-flight entries are discarded.

Optional Feature:
RS_AGE_PRIORITY_EN
- Defined: each entry has an age counter of $clog2(DEPTH) bits.
  - It is set to 0 on allocation.
  - It increments on every accepted dispatch while the entry is valid, saturating.
  - Select picks the eligible entry with the largest age, so issue is oldest-first. Ties go to the lowest index.
- Undefined: no age state; select is lowest-index eligible.
- All other behaviour is identical either way.

Test Plan:
- Reset/fill: hold rst=0 two cycles, then dispatch 8 ops with both rdy=1 and issue_ready=0 → occupancy counts to 8, dispatch_ready=0 after the 8th, a 9th dispatch is ignored. Then issue_ready=1 → entries issue one per cycle in index order 0..7.
- Wakeup: dispatch with rs1_tag=5 (not ready), rs2_tag=0 → no issue. cdb_valid=01, cdb_tag[0]=5 at cycle N → issue_valid=1 in cycle N+1 with issue_rs1_tag=5, issue_rs2_tag=0.
- Dispatch/CDB race: dispatch rs1_tag=9 rdy=0 in the same cycle as cdb port1 broadcasting 9 → issue_valid=1 the next cycle.
- Simultaneous dispatch and issue at occupancy 8: issue_ready=1 and dispatch_valid=1 → dispatch rejected (dispatch_ready=0), occupancy 7. Next cycle the dispatch is accepted and occupancy stays 7 with a concurrent issue.
- Flush: 5 entries valid, flush=1 with dispatch_valid=1 → issue_valid=0 that cycle, occupancy=0 next cycle, no stale issue afterward.
- RS_AGE_PRIORITY_EN: dispatch A into entry 3 (not ready), then B into entry 0 (ready); wake A → A issues before B. Without the macro, B issues first.
